silife_wb_master: RTL
=====================

// Module: silife_wb_master
// PURPOSE
//  Wishbone classic initiator driving the silife register/cell responder (e.g. from a
//  boot/pattern loader or test sequencer). Accepts one command at a time on a
//  valid/ready port, runs one single-beat bus cycle and returns a response word.
//  Pairs directly with the silife responder: 32-bit address, 32-bit data, no SEL.
// PARAMETERS
//  TIMEOUT_CYCLES  255  bus cycles to wait for i_wb_ack before aborting (1..65535)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   asynchronous, active-high reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   master can accept a command this cycle
//  cmd_we       in   1   1 = write, 0 = read
//  cmd_addr     in   32  target byte address
//  cmd_wdata    in   32  write data (ignored for reads)
//  rsp_valid    out  1   response available
//  rsp_ready    in   1   consumer takes response
//  rsp_data     out  32  read data; 0 for writes and errors
//  rsp_err      out  1   1 = transaction aborted by timeout
//  busy         out  1   state != IDLE
//  o_wb_cyc     out  1   bus cycle
//  o_wb_stb     out  1   strobe
//  o_wb_we      out  1   write enable
//  o_wb_addr    out  32  address
//  o_wb_data    out  32  write data
//  i_wb_ack     in   1   responder acknowledge
//  i_wb_data    in   32  responder read data
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; every output 0 except cmd_ready=1.
//  - FSM: IDLE -> BUS on cmd_valid&cmd_ready; BUS -> RESP on i_wb_ack or timeout;
//    RESP -> IDLE on rsp_ready.
//  - cmd_ready = (state==IDLE), registered-free decode; no command buffering.
//  - Command accepted at edge N: from N+1 o_wb_cyc=o_wb_stb=1, o_wb_we/addr/data
//    hold the latched command, stable until the cycle ends.
//  - i_wb_ack sampled 1 in BUS at edge M: cyc/stb/we drop to 0 from M+1; rsp_valid=1
//    from M+1; rsp_data = i_wb_data sampled at M for reads, 0 for writes; rsp_err=0.
//    o_wb_addr/o_wb_data retain their last values (don't-care while cyc=0).
//  - Minimum cmd-accept to rsp_valid latency: 2 cycles (ack on first BUS edge).
//    With the silife responder (registered ack) latency is 3 cycles.
//  - Response held stable until rsp_valid&rsp_ready; cleared on the next edge and
//    state returns to IDLE; cmd_ready rises the same cycle, so back-to-back cycles
//    have >=1 idle bus cycle between them (stb never held across transactions).
//  - i_wb_ack while not in BUS is ignored (stale ack from responder tail).
//  - Ack coincident with timeout expiry: ack wins, rsp_err=0.
//  - Reset mid-transaction: bus released asynchronously, pending response lost.
// CONFIGURATION
//  SILIFE_WBM_TIMEOUT_EN defined: 16-bit counter cleared on entering BUS, increments
//   each BUS cycle without ack; reaching TIMEOUT_CYCLES ends the cycle exactly as an
//   ack would but with rsp_err=1, rsp_data=0.
//  Not defined: no counter; BUS waits indefinitely for ack; rsp_err tied to 0.
// TESTING
//  1 write cmd addr=0x0 data=0x1, responder acks 2 edges after stb -> cyc/stb high
//    2 cycles, we=1, rsp_valid with rsp_err=0, rsp_data=0x0.
//  2 read addr=0x0 after (1), responder returns 0x0000_0003 -> rsp_data=0x00000003,
//    cmd_ready low from accept until rsp handshake.
//  3 hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/data stable, cyc=0,
//    cmd_ready=0; release -> IDLE next edge, second cmd accepted.
//  4 TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> stb high 4 cycles, then rsp_err=1,
//    rsp_data=0; without macro bus stays asserted 100 cycles, no response.
//  5 reset asserted mid-BUS (between edges) -> cyc/stb/rsp_valid 0 immediately,
//    cmd_ready=1 after deassert; spurious ack in IDLE produces no response.

Source files
------------

// File: rtl/silife_wb_master.sv
// Single-beat Wishbone classic initiator for the silife responder: valid/ready command in,
// one bus cycle, registered response out. Optional ack timeout via SILIFE_WBM_TIMEOUT_EN.
module silife_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_t;

  state_t state;

`ifdef SILIFE_WBM_TIMEOUT_EN
  localparam logic [15:0] TimeoutLimit = TIMEOUT_CYCLES[15:0];

  logic [15:0] tmo_cnt;
  logic [15:0] tmo_cnt_next;
  logic        err_q;

  assign tmo_cnt_next = tmo_cnt + 16'd1;
  assign rsp_err      = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign rsp_err            = 1'b0;
`endif

  assign cmd_ready = (state == StIdle);
  assign busy      = (state != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_wb_we   <= 1'b0;
      o_wb_addr <= 32'h0;
      o_wb_data <= 32'h0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
`ifdef SILIFE_WBM_TIMEOUT_EN
      tmo_cnt   <= 16'h0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (cmd_valid) begin
            state     <= StBus;
            o_wb_cyc  <= 1'b1;
            o_wb_stb  <= 1'b1;
            o_wb_we   <= cmd_we;
            o_wb_addr <= cmd_addr;
            o_wb_data <= cmd_wdata;
`ifdef SILIFE_WBM_TIMEOUT_EN
            tmo_cnt   <= 16'h0;
`endif
          end
        end
        StBus: begin
          // Ack takes priority over a coincident timeout.
          if (i_wb_ack) begin
            state     <= StResp;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= o_wb_we ? 32'h0 : i_wb_data;
`ifdef SILIFE_WBM_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (tmo_cnt_next == TimeoutLimit) begin
            state     <= StResp;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= 32'h0;
            err_q     <= 1'b1;
          end else begin
            tmo_cnt   <= tmo_cnt_next;
`endif
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state     <= StIdle;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'h0;
`ifdef SILIFE_WBM_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
